// File: rtl/axi4_wr_burst_engine.sv
// axi4_wr_burst_engine
// Converts a (start address, beat count) command plus a payload stream into
// AXI4 INCR write bursts. Bursts never cross a 4 KB boundary and are capped
// at MAX_LEN beats. At most MAX_OUTSTANDING bursts may await their write
// response. When the last response arrives, the worst BRESP is reported
// with a one-cycle status pulse.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   cmd_addr, cmd_beats        command: start byte address, length in beats
//   cmd_valid, cmd_ready       command handshake (ready only when idle)
//   i_tdata/i_tvalid/i_tready  payload stream, passed straight to the W channel
//   awid..awvalid, awready     AXI4 write-address channel
//   wdata..wvalid, wready      AXI4 write-data channel
//   bid, bresp, bvalid, bready AXI4 write-response channel (bid ignored)
//   sts_valid, sts_resp        completion pulse and worst response seen

module axi4_wr_burst_engine #(
  parameter int DWIDTH          = 64,
  parameter int AWIDTH          = 32,
  parameter int IDWIDTH         = 4,
  parameter int AXI_ID          = 0,
  parameter int MAX_LEN         = 256,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic [AWIDTH-1:0]     cmd_addr,
  input  logic [15:0]           cmd_beats,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,

  input  logic [DWIDTH-1:0]     i_tdata,
  input  logic                  i_tvalid,
  output logic                  i_tready,

  output logic [IDWIDTH-1:0]    awid,
  output logic [AWIDTH-1:0]     awaddr,
  output logic [7:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic                  awvalid,
  input  logic                  awready,

  output logic [DWIDTH-1:0]     wdata,
  output logic [DWIDTH/8-1:0]   wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,

  input  logic [IDWIDTH-1:0]    bid,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,

  output logic                  sts_valid,
  output logic [1:0]            sts_resp
);

  localparam int BYTES = DWIDTH / 8;
  localparam int SIZE  = $clog2(BYTES);
  localparam logic [AWIDTH-1:0] ALIGN_MASK = ~(AWIDTH'(BYTES - 1));

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    WAIT_B
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [AWIDTH-1:0] addr;
  logic [15:0]       remaining;
  logic [7:0]        beat;
  logic [3:0]        outstanding;
  logic [1:0]        acc;

  logic [12:0]       room_4k;
  logic [16:0]       len_cap;
  logic [8:0]        blen;
  logic              last_beat;

  logic              cmd_hs;
  logic              aw_hs;
  logic              w_hs;
  logic              b_hs;
  logic              unused_bid;

  assign unused_bid = ^bid;

  // Current burst length. It depends only on addr and remaining, and both
  // stay frozen from ADDR until the wlast handshake. The same value
  // therefore drives awlen and the beat count for the W channel.
  always_comb begin
    room_4k   = (13'h1000 - {1'b0, addr[11:0]}) >> SIZE;
    len_cap   = (17'(remaining) < 17'(MAX_LEN)) ? 17'(remaining) : 17'(MAX_LEN);
    blen      = (len_cap < 17'(room_4k)) ? 9'(len_cap) : 9'(room_4k);
    last_beat = (beat == 8'(blen - 9'd1));
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    awvalid   = 1'b0;
    awaddr    = '0;
    awlen     = '0;
    awsize    = '0;
    awburst   = '0;
    awid      = '0;
    wvalid    = 1'b0;
    wdata     = '0;
    wstrb     = '0;
    wlast     = 1'b0;
    i_tready  = 1'b0;
    bready    = ~reset;
    if (!reset) begin
      case (state)
        IDLE: begin
          cmd_ready = 1'b1;
          if (cmd_valid && cmd_beats != '0) begin
            state_nxt = ADDR;
          end
        end
        ADDR: begin
          awvalid = (outstanding < 4'(MAX_OUTSTANDING));
          awaddr  = addr;
          awlen   = 8'(blen - 9'd1);
          awsize  = 3'(SIZE);
          awburst = 2'b01;
          awid    = IDWIDTH'(AXI_ID);
          if (awvalid && awready) begin
            state_nxt = DATA;
          end
        end
        DATA: begin
          wvalid   = i_tvalid;
          i_tready = wready;
          wdata    = i_tdata;
          wstrb    = '1;
          wlast    = last_beat;
          if (i_tvalid && wready && last_beat) begin
            state_nxt = (remaining == 16'(blen)) ? WAIT_B : ADDR;
          end
        end
        WAIT_B: begin
          if (outstanding == '0) begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign cmd_hs = cmd_valid & cmd_ready;
  assign aw_hs  = awvalid & awready;
  assign w_hs   = wvalid & wready;
  assign b_hs   = bvalid & bready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      addr        <= '0;
      remaining   <= '0;
      beat        <= '0;
      outstanding <= '0;
      acc         <= '0;
      sts_valid   <= 1'b0;
      sts_resp    <= '0;
    end else begin
      state <= state_nxt;

      if (cmd_hs) begin
        addr      <= cmd_addr & ALIGN_MASK;
        remaining <= cmd_beats;
        beat      <= '0;
      end else if (w_hs) begin
        if (last_beat) begin
          addr      <= addr + (AWIDTH'(blen) << SIZE);
          remaining <= remaining - 16'(blen);
          beat      <= '0;
        end else begin
          beat <= beat + 8'd1;
        end
      end

      // Simultaneous AW and B handshakes cancel out.
      if (aw_hs && !b_hs) begin
        outstanding <= outstanding + 4'd1;
      end else if (b_hs && !aw_hs && outstanding != '0) begin
        outstanding <= outstanding - 4'd1;
      end

      if (cmd_hs) begin
        acc <= '0;
      end else if (b_hs && bresp > acc) begin
        acc <= bresp;
      end

      // Status is registered. The accumulator therefore already holds the
      // final response, and a zero-beat command reports on the next cycle.
      sts_valid <= 1'b0;
      sts_resp  <= '0;
      if (cmd_hs && cmd_beats == '0) begin
        sts_valid <= 1'b1;
      end else if (state == WAIT_B && outstanding == '0) begin
        sts_valid <= 1'b1;
        sts_resp  <= acc;
      end
    end
  end

endmodule

// File: tb/tb_axi4_wr_burst_engine.sv
module tb_axi4_wr_burst_engine;

  localparam int DW   = 64;
  localparam int AWD  = 32;
  localparam int IDW  = 4;
  localparam int AXID = 5;
  localparam int MAXO = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [AWD-1:0]  cmd_addr;
  logic [15:0]     cmd_beats;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [DW-1:0]   i_tdata;
  logic            i_tvalid;
  logic            i_tready;
  logic [IDW-1:0]  awid;
  logic [AWD-1:0]  awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic            awvalid;
  logic            awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;
  logic [IDW-1:0]  bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  logic            sts_valid;
  logic [1:0]      sts_resp;

  axi4_wr_burst_engine #(
    .DWIDTH(DW), .AWIDTH(AWD), .IDWIDTH(IDW), .AXI_ID(AXID),
    .MAX_LEN(256), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_addr(cmd_addr), .cmd_beats(cmd_beats), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .i_tdata(i_tdata), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .sts_valid(sts_valid), .sts_resp(sts_resp)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  int unsigned cyc   = 0;
  int          tb_outst = 0;
  bit          mon_en   = 1'b0;
  bit          b_enable = 1'b1;
  bit          aw_hold  = 1'b0;
  logic [39:0] aw_saved;

  logic [39:0]  exp_aw[$];     // {awaddr, awlen}
  logic [64:0]  exp_w[$];      // {wdata, wlast}
  logic [1:0]   exp_sts[$];
  logic [63:0]  src_q[$];
  logic [1:0]   bresp_q[$];
  logic [1:0]   b_pend[$];
  logic [1:0]   forced_resp[$];
  int unsigned  aw_cyc_q[$];
  int unsigned  b_cyc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic finish_run;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string what);
    total++;
    bad++;
    $display("FAIL timeout_%s: got no completion, expected it within the cycle budget", what);
    finish_run();
  endtask

  // Reference model: splits the command into 4 KB-safe bursts of at most
  // 256 beats, and queues the expected AW and W traffic plus the final status.
  task automatic send_cmd(input logic [31:0] a_in, input int unsigned beats);
    logic [31:0] a;
    int unsigned rem;
    int unsigned room;
    int unsigned len;
    int unsigned n;
    logic [1:0]  r;
    logic [1:0]  worst;
    logic [63:0] d;
    a     = a_in & 32'hFFFF_FFF8;
    rem   = beats;
    worst = 2'd0;
    while (rem > 0) begin
      room = (4096 - (a & 32'h0000_0FFF)) / 8;
      len  = rem;
      if (len > 256)  len = 256;
      if (len > room) len = room;
      exp_aw.push_back({a, 8'(len - 1)});
      for (int unsigned k = 0; k < len; k++) begin
        d = {$urandom, $urandom};
        src_q.push_back(d);
        exp_w.push_back({d, 1'(k == len - 1)});
      end
      if (forced_resp.size() > 0) r = forced_resp.pop_front();
      else                        r = 2'($urandom_range(0, 3));
      bresp_q.push_back(r);
      if (r > worst) worst = r;
      a   = a + 32'(len * 8);
      rem = rem - len;
    end
    exp_sts.push_back(worst);
    @(posedge clk); #1;
    cmd_addr  = a_in;
    cmd_beats = 16'(beats);
    cmd_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n > 20000) timeout_fail("cmd_ready");
    end while (!cmd_ready);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int unsigned limit, input string tag);
    int unsigned n = 0;
    while (exp_sts.size() != 0 || exp_aw.size() != 0 || exp_w.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > limit) timeout_fail(tag);
    end
    @(posedge clk); #1;
  endtask

  // Slave side and payload source: random back-pressure. A B response is
  // released only after the wlast of its burst.
  initial begin : slave_drv
    bit w_took;
    bit w_last_took;
    bit b_took;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'd0; bid = '0;
    i_tvalid = 1'b0; i_tdata = '0;
    forever begin
      @(negedge clk);
      w_took      = i_tvalid && i_tready;
      w_last_took = w_took && wlast;
      b_took      = bvalid && bready;
      @(posedge clk); #1;
      if (w_took && src_q.size() > 0) void'(src_q.pop_front());
      if (w_last_took && bresp_q.size() > 0) b_pend.push_back(bresp_q.pop_front());
      if (b_took && b_pend.size() > 0) void'(b_pend.pop_front());
      if (bvalid && !b_took && b_pend.size() > 0) begin
        bresp = b_pend[0];
      end else if (b_enable && b_pend.size() > 0 && $urandom_range(0, 2) != 0) begin
        bvalid = 1'b1;
        bresp  = b_pend[0];
        bid    = 4'($urandom);
      end else begin
        bvalid = 1'b0;
        bresp  = 2'd0;
      end
      awready = ($urandom_range(0, 3) != 0);
      wready  = ($urandom_range(0, 3) != 0);
      if (src_q.size() > 0 && ((i_tvalid && !w_took) || $urandom_range(0, 4) != 0)) begin
        i_tvalid = 1'b1;
        i_tdata  = src_q[0];
      end else begin
        i_tvalid = 1'b0;
        i_tdata  = '0;
      end
    end
  end

  initial begin : monitor
    logic [39:0] ea;
    logic [64:0] ew;
    logic [1:0]  es;
    forever begin
      @(negedge clk);
      if (mon_en && !reset) begin
        if (tb_outst >= MAXO) check("aw_limit", awvalid, 0);
        if (awvalid) begin
          if (aw_hold) check("aw_stable", {awaddr, awlen}, aw_saved);
          aw_saved = {awaddr, awlen};
          aw_hold  = !awready;
        end else if (aw_hold) begin
          check("aw_dropped", awvalid, 1);
          aw_hold = 1'b0;
        end
        if (awvalid && awready) begin
          if (exp_aw.size() == 0) begin
            total++; bad++;
            $display("FAIL aw_unexpected: got AW addr 0x%0h, expected none", awaddr);
          end else begin
            ea = exp_aw.pop_front();
            check("awaddr", awaddr, ea[39:8]);
            check("awlen", awlen, ea[7:0]);
          end
          check("awsize", awsize, 3);
          check("awburst", awburst, 1);
          check("awid", awid, AXID);
          aw_cyc_q.push_back(cyc);
        end
        if (wvalid && wready) begin
          if (exp_w.size() == 0) begin
            total++; bad++;
            $display("FAIL w_unexpected: got W beat 0x%0h, expected none", wdata);
          end else begin
            ew = exp_w.pop_front();
            check("wdata", wdata, ew[64:1]);
            check("wlast", wlast, ew[0]);
          end
          check("wstrb", wstrb, 8'hFF);
        end
        if (bvalid && bready) b_cyc_q.push_back(cyc);
        if (sts_valid) begin
          if (exp_sts.size() == 0) begin
            total++; bad++;
            $display("FAIL sts_unexpected: got sts pulse resp %0d, expected none", sts_resp);
          end else begin
            es = exp_sts.pop_front();
            check("sts_resp", sts_resp, es);
          end
        end else begin
          check("sts_resp_idle", sts_resp, 0);
        end
        tb_outst = tb_outst + int'(awvalid && awready) - int'(bvalid && bready);
      end
    end
  end

  initial begin : watchdog
    #900000;
    total++;
    bad++;
    $display("FAIL watchdog: got no end of test, expected finish within time limit");
    finish_run();
  end

  initial begin : main
    int unsigned base_aw;
    int unsigned base_b;
    int unsigned n;
    logic [31:0] a;
    int unsigned beats;

    reset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_beats = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_awvalid", awvalid, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_i_tready", i_tready, 0);
    check("rst_wlast", wlast, 0);
    check("rst_bready", bready, 0);
    check("rst_sts_valid", sts_valid, 0);
    check("rst_sts_resp", sts_resp, 0);
    check("rst_aw_fields", {awaddr, awlen, awsize, awburst, awid}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_cmd_ready", cmd_ready, 1);
    check("post_rst_bready", bready, 1);
    mon_en = 1'b1;

    // Single aligned burst, OKAY response.
    forced_resp.push_back(2'd0);
    send_cmd(32'h0000_1000, 16);
    wait_done(5000, "single_burst");

    // Split at the 4 KB boundary.
    send_cmd(32'h0000_0FC0, 16);
    wait_done(5000, "split_4k");

    // 600 beats -> 256/256/88. Worst of OKAY, SLVERR, OKAY is 2.
    forced_resp.push_back(2'd0);
    forced_resp.push_back(2'd2);
    forced_resp.push_back(2'd0);
    send_cmd(32'h0000_0000, 600);
    wait_done(20000, "long_cmd");

    // Zero-beat command: immediate status pulse, no AW.
    send_cmd(32'h0000_3000, 0);
    @(negedge clk);
    check("zero_sts_valid", sts_valid, 1);
    check("zero_sts_resp", sts_resp, 0);
    check("zero_cmd_ready", cmd_ready, 1);
    for (int unsigned k = 0; k < 4; k++) begin
      @(negedge clk);
      check("zero_no_awvalid", awvalid, 0);
    end
    wait_done(100, "zero_beats");

    // With B held off, the third AW must wait for the first B handshake.
    b_enable = 1'b0;
    base_aw  = aw_cyc_q.size();
    base_b   = b_cyc_q.size();
    send_cmd(32'h0000_0000, 600);
    n = 0;
    while (exp_w.size() > 88) begin
      @(negedge clk);
      n++;
      if (n > 20000) timeout_fail("two_bursts");
    end
    repeat (30) @(negedge clk);
    check("aw_count_at_limit", aw_cyc_q.size(), base_aw + 2);
    check("awvalid_at_limit", awvalid, 0);
    b_enable = 1'b1;
    n = 0;
    while (aw_cyc_q.size() < base_aw + 3) begin
      @(negedge clk);
      n++;
      if (n > 5000) timeout_fail("third_aw");
    end
    if (b_cyc_q.size() > base_b)
      check("third_aw_after_b", aw_cyc_q[base_aw + 2] > b_cyc_q[base_b], 1);
    else
      check("b_before_third_aw", b_cyc_q.size(), base_b + 1);
    wait_done(20000, "outstanding");

    // Reset in the middle of DATA abandons the command silently.
    send_cmd(32'h0000_2000, 64);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n > 5000) timeout_fail("reach_data");
    end while (!wvalid);
    @(posedge clk); #1;
    mon_en = 1'b0;
    reset  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_awvalid", awvalid, 0);
    check("midrst_wvalid", wvalid, 0);
    check("midrst_i_tready", i_tready, 0);
    check("midrst_sts_valid", sts_valid, 0);
    exp_aw.delete(); exp_w.delete(); exp_sts.delete();
    src_q.delete(); bresp_q.delete(); b_pend.delete();
    tb_outst = 0;
    aw_hold  = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("midrst_cmd_ready", cmd_ready, 1);
    mon_en = 1'b1;
    for (int unsigned k = 0; k < 5; k++) begin
      @(negedge clk);
      check("midrst_no_sts", sts_valid, 0);
    end

    // Randomised commands: addresses often near a 4 KB edge, mixed lengths.
    for (int unsigned k = 0; k < 20; k++) begin
      a = $urandom_range(0, 32'h0FFF_FFFF);
      if ($urandom_range(0, 1) != 0) a[11:0] = 12'hE00 + 12'($urandom_range(0, 511));
      case ($urandom_range(0, 5))
        0:       beats = 0;
        1:       beats = $urandom_range(1, 4);
        default: beats = $urandom_range(1, 300);
      endcase
      send_cmd(a, beats);
    end
    wait_done(40000, "random");

    finish_run();
  end

endmodule
